spi_master: RTL and testbench
=============================

# spi_master

SPI controller (mode 0, MSB first) that drives `sck`/`ss`/`mosi` and samples `miso`, making it the initiating end for the SPI peripherals in the perip tree, bitrev-style slaves included. The CPU-side bus bridge issues one transfer at a time through a valid/ready request channel and collects the received bits on a valid/ready response channel. Serial clock, chip selects and data are all generated from the single system clock by a programmable divider.

## Interface
- `DATA_W`, 16: maximum bits per transfer; shift register width.
- `SS_W`, 8: number of chip-select lines.
- `DIV_W`, 16: width of the divider value.
- `LEN_W`, `$clog2(DATA_W)`: width of `req_len`.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  transfer request present.
- `req_ready`  out  1  high only in IDLE.
- `req_data`  in  DATA_W  transmit bits, right-aligned; bit `len-1` sent first.
- `req_len`  in  LEN_W  bit count; 0 encodes DATA_W.
- `req_ss`  in  SS_W  one-hot select mask; selected lines driven low.
- `req_div`  in  DIV_W  half-period of `sck` minus 1, in `clock` cycles.
- `resp_valid`  out  1  received data available.
- `resp_ready`  in  1  consumer accepts response.
- `resp_data`  out  DATA_W  received bits, right-aligned; bits at `len` and above are 0.
- `sck`  out  1  serial clock, idle low.
- `ss`  out  SS_W  active-low selects.
- `mosi`  out  1  serial data out, idle 1.
- `miso`  in  1  serial data in.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, RESP.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, latch data, len, ss mask, div; go to SETUP.
- SETUP: `ss` = ~mask, `sck`=0, `mosi` = bit `len-1`. Lasts one half-period, then HIGH.
- HIGH: `sck`=1, so the slave samples on the rising edge. Lasts one half-period, then LOW.
- At the HIGH→LOW transition (falling edge), shift the current `miso` value into the receive LSB, decrement the remaining-bit count, and drive `mosi` to the next bit. After the last bit, `mosi` returns to 1.
- LOW: `sck`=0, lasts one half-period. Goes to HIGH if bits remain, otherwise to HOLD.
- HOLD: `ss` all ones, `sck`=0, `mosi`=1, for one half-period, then RESP.
- RESP: `resp_valid`=1 with `resp_data` held stable until `resp_ready`. The handshake cycle returns to IDLE.
- `req_ss`=0 is legal: the transfer runs with no select asserted. A multi-hot mask drives all selected lines.
- Reset: `sck`=0, `ss`=all ones, `mosi`=1, `req_ready`=1, `resp_valid`=0, `resp_data`=0, state IDLE.
- Reset mid-transfer aborts with no response; the reset values are visible the cycle after reset is sampled.

## Timing
- Half-period = `req_div`+1 clock cycles, generated by a down-counter reloaded at each phase change. `req_div`=0 gives `sck` = `clock`/2.
- Transfer = 2·len+2 half-periods: SETUP, len×(HIGH, LOW), HOLD.
- Request accepted at edge t → `ss` low from t+1. `resp_valid` first high at t+1+(2·len+2)(div+1).
- Each `miso` sample is taken at the end of a HIGH phase, one half-period after the rising edge. A slave that updates `miso` on the rising edge is therefore sampled safely.
- No new request is accepted until the response handshake completes: `req_ready` is 0 from SETUP through RESP. The cycle after the handshake is IDLE, where `req_ready`=1.
- Counter arithmetic is unsigned, with no wrap: the bit count is LEN_W+1 bits wide so that DATA_W is representable.

## Structure
- Package `spi_pkg`: the state enum and the idle `mosi` level constant.
- Sub-module `spi_clkdiv`: reloadable half-period down-counter emitting a one-cycle `tick`. It is cleared by reset and on request accept.

## Test plan
- Reset → `sck`=0, `ss`=8'hFF, `mosi`=1, `req_ready`=1, `resp_valid`=0.
- Loopback (`miso`=`mosi`), len=8, data=16'h005A, div=0, ss=8'h01 → `ss`=8'hFE during the transfer, 8 rising edges, `resp_data`=16'h005A, `resp_valid` 19 cycles after accept.
- Bitrev-style slave (shifts in 8 bits with `miso`=1, then returns them MSB first), len=0 (16 bits), data=16'hA500 → `resp_data`=16'hFFA5.
- div=3, len=4, loopback, data=4'hC → each `sck` high lasts 4 cycles, `resp_data`=16'h000C, `resp_valid` 41 cycles after accept.
- `resp_ready` held low 5 cycles in RESP → `resp_valid` and `resp_data` stable, `req_ready`=0. A second request held valid is accepted the cycle after the response handshake.
- Reset asserted during the third HIGH phase → next cycle `ss`=all ones, `sck`=0, `mosi`=1, no `resp_valid`. A following loopback transfer completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller state encoding and idle line level.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period timer: tick is high for the last cycle of each (div+1)-cycle phase.
// Reloads itself on every tick; load restarts a full phase with a new divider.
module spi_clkdiv #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] reload;
  logic [DIV_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= div;
      count  <= div;
    end else if (count == '0) begin
      count <= reload;
    end else begin
      count <= count - DIV_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: one request in flight, response after (2*len+2)*(div+1) cycles.
// req_ready only in IDLE; response is held in RESP until resp_ready, no new request meanwhile.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SS_W   = 8,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [SS_W-1:0]   req_ss,
  input  logic [DIV_W-1:0]  req_div,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sck,
  output logic [SS_W-1:0]   ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = LEN_W + 1;

  state_t            state;
  logic [DATA_W-1:0] tx;
  logic [CNT_W-1:0]  bits_left;
  logic [CNT_W-1:0]  len_eff;
  logic [DATA_W-1:0] aligned;
  logic              accept;
  logic              tick;

  assign accept  = (state == ST_IDLE) && req_valid;
  assign len_eff = (req_len == '0) ? CNT_W'(DATA_W) : {1'b0, req_len};
  // Left-justify the payload so the first bit to send always sits at the MSB.
  assign aligned = req_data << (CNT_W'(DATA_W) - len_eff);

  spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .div   (req_div),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sck        <= 1'b0;
      ss         <= '1;
      mosi       <= MOSI_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      tx         <= '0;
      bits_left  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_SETUP;
            req_ready <= 1'b0;
            ss        <= ~req_ss;
            sck       <= 1'b0;
            mosi      <= aligned[DATA_W-1];
            tx        <= aligned;
            bits_left <= len_eff;
            resp_data <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_HIGH;
            sck   <= 1'b1;
          end
        end
        ST_HIGH: begin
          // Falling edge: sample miso a full half-period after the slave saw the rising edge.
          if (tick) begin
            state     <= ST_LOW;
            sck       <= 1'b0;
            resp_data <= {resp_data[DATA_W-2:0], miso};
            bits_left <= bits_left - CNT_W'(1);
            tx        <= tx << 1;
            mosi      <= (bits_left == CNT_W'(1)) ? MOSI_IDLE : tx[DATA_W-2];
          end
        end
        ST_LOW: begin
          if (tick) begin
            if (bits_left != '0) begin
              state <= ST_HIGH;
              sck   <= 1'b1;
            end else begin
              state <= ST_HOLD;
              ss    <= '1;
              mosi  <= MOSI_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and bit-reversing slave models, stall and reset cases.
module tb_spi_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_len;
  logic [7:0]  req_ss;
  logic [15:0] req_div;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        sck;
  logic [7:0]  ss;
  logic        mosi;
  logic        miso;

  int checks = 0;
  int failures = 0;

  // Slave model: mode 0 selects loopback, mode 1 the bit-reversing slave.
  logic       mode;
  logic       slave_clr;
  int         scnt;
  logic [7:0] scap;

  spi_master dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_len    (req_len),
    .req_ss     (req_ss),
    .req_div    (req_div),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sck        (sck),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge sck or posedge slave_clr) begin
    if (slave_clr) begin
      scnt <= 0;
      scap <= 8'h00;
    end else begin
      if (scnt < 8) scap <= {scap[6:0], mosi};
      scnt <= scnt + 1;
    end
  end

  always_comb begin
    miso = 1'b1;
    if (mode == 1'b0) miso = mosi;
    else if (scnt > 8 && scnt <= 16) miso = scap[16-scnt];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request with resp_ready high; returns cycles from accept to resp_valid.
  task automatic run_xfer(input logic [15:0] d, input logic [3:0] l, input logic [7:0] m,
                          input logic [15:0] dv, output int lat, output logic [15:0] rd,
                          output logic [7:0] ss_seen, output int rises,
                          output int hi_min, output int hi_max);
    int run;
    logic prev;
    req_data   = d;
    req_len    = l;
    req_ss     = m;
    req_div    = dv;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    lat     = 1;
    ss_seen = ss;
    rises   = 0;
    hi_min  = 9999;
    hi_max  = 0;
    run     = 0;
    prev    = 1'b0;
    while (!resp_valid && lat < 2000) begin
      if (sck && !prev) rises++;
      if (sck) run++;
      else if (run > 0) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
      end
      prev = sck;
      tick();
      lat++;
    end
    rd = resp_data;
    tick();
  endtask

  int          lat, rises, hi_min, hi_max, n, vcount;
  logic [15:0] rd;
  logic [7:0]  ss_seen;
  logic        prev_sck;

  initial begin
    mode       = 1'b0;
    slave_clr  = 1'b0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_data   = 16'h0000;
    req_len    = 4'd0;
    req_ss     = 8'h00;
    req_div    = 16'h0000;
    resp_ready = 1'b1;
    tick();
    tick();
    chk("reset_sck", sck, 1'b0);
    chk("reset_ss", ss, 8'hFF);
    chk("reset_mosi", mosi, 1'b1);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp_data", resp_data, 16'h0000);
    reset = 1'b0;
    tick();

    // Loopback, 8 bits, fastest clock.
    run_xfer(16'h005A, 4'd8, 8'h01, 16'd0, lat, rd, ss_seen, rises, hi_min, hi_max);
    chk("lb8_ss", ss_seen, 8'hFE);
    chk("lb8_latency", lat, 19);
    chk("lb8_rises", rises, 8);
    chk("lb8_data", rd, 16'h005A);
    chk("lb8_idle_req_ready", req_ready, 1'b1);
    chk("lb8_idle_resp_valid", resp_valid, 1'b0);

    // Bit-reversing slave, full 16-bit transfer.
    mode = 1'b1;
    slave_clr = 1'b1;
    #1;
    slave_clr = 1'b0;
    run_xfer(16'hA500, 4'd0, 8'h01, 16'd0, lat, rd, ss_seen, rises, hi_min, hi_max);
    chk("brev_data", rd, 16'hFFA5);
    chk("brev_latency", lat, 35);
    chk("brev_rises", rises, 16);
    mode = 1'b0;

    // Slow clock, 4 bits.
    run_xfer(16'h000C, 4'd4, 8'h01, 16'd3, lat, rd, ss_seen, rises, hi_min, hi_max);
    chk("div3_data", rd, 16'h000C);
    chk("div3_latency", lat, 41);
    chk("div3_high_min", hi_min, 4);
    chk("div3_high_max", hi_max, 4);
    chk("div3_rises", rises, 4);

    // No select asserted.
    run_xfer(16'h00B1, 4'd8, 8'h00, 16'd0, lat, rd, ss_seen, rises, hi_min, hi_max);
    chk("nosel_ss", ss_seen, 8'hFF);
    chk("nosel_data", rd, 16'h00B1);

    // Stalled response with a second request waiting.
    resp_ready = 1'b0;
    req_data   = 16'h003C;
    req_len    = 4'd8;
    req_ss     = 8'h01;
    req_div    = 16'd0;
    req_valid  = 1'b1;
    tick();
    req_data = 16'h0123;
    req_len  = 4'd12;
    req_ss   = 8'h06;
    n = 0;
    while (!resp_valid && n < 500) begin
      tick();
      n++;
    end
    chk("stall_first_data", resp_data, 16'h003C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_resp_valid", resp_valid, 1'b1);
      chk("stall_resp_data", resp_data, 16'h003C);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    tick();
    chk("post_hs_req_ready", req_ready, 1'b1);
    chk("post_hs_resp_valid", resp_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("second_ss_multihot", ss, 8'hF9);
    chk("second_req_ready", req_ready, 1'b0);
    n = 0;
    while (!resp_valid && n < 500) begin
      tick();
      n++;
    end
    chk("second_data", resp_data, 16'h0123);
    tick();

    // Reset during the third HIGH phase.
    req_data  = 16'h00FF;
    req_len   = 4'd8;
    req_ss    = 8'h01;
    req_div   = 16'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rises = 0;
    prev_sck = 1'b0;
    n = 0;
    while (rises < 3 && n < 500) begin
      tick();
      n++;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
    end
    chk("abort_reached_third_high", rises, 3);
    reset = 1'b1;
    tick();
    chk("abort_ss", ss, 8'hFF);
    chk("abort_sck", sck, 1'b0);
    chk("abort_mosi", mosi, 1'b1);
    chk("abort_resp_valid", resp_valid, 1'b0);
    chk("abort_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (resp_valid) vcount++;
    end
    chk("abort_no_response", vcount, 0);
    run_xfer(16'h0096, 4'd8, 8'h01, 16'd0, lat, rd, ss_seen, rises, hi_min, hi_max);
    chk("after_abort_data", rd, 16'h0096);
    chk("after_abort_latency", lat, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
